// File: rtl/counter_wrap_monitor.sv
// Wrap/error monitor for the 4-bit up-counter: counts wraps, raises a handshaked
// interrupt every IRQ_THRESH wraps, flags protocol errors and captures snapshots.
module counter_wrap_monitor #(
    parameter int CNT_W      = 4,
    parameter int WRAP_W     = 8,
    parameter int IRQ_THRESH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              ovf_in,
    input  logic              irq_ack,
    input  logic              snap_req,
    input  logic              err_clr,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              wrap_sat,
    output logic              irq,
    output logic [1:0]        err,
    output logic              snap_valid,
    output logic [CNT_W-1:0]  snap_cnt,
    output logic [WRAP_W-1:0] snap_wraps
);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] THRESH   = WRAP_W'(IRQ_THRESH);

    logic [CNT_W-1:0]  cnt_prev;
    logic              ovf_prev;
    logic              primed;
    logic [WRAP_W-1:0] pend_cnt;

    logic [CNT_W-1:0]  cnt_inc;
    logic              wrap_ev;
    logic              ill_step;
    logic [WRAP_W-1:0] wrap_nxt;
    logic [WRAP_W-1:0] pend_nxt;
    logic [1:0]        err_nxt;

    // Debug tap: previous overflow level, kept for the rising-edge trace only.
    logic unused_ovf_trace;
    assign unused_ovf_trace = ovf_prev;

    always_comb begin
        cnt_inc  = cnt_prev + 1'b1;
        wrap_ev  = primed && (cnt_prev == CNT_MAX) && (cnt_in == '0);
        ill_step = primed && (cnt_in != cnt_prev) && (cnt_in != cnt_inc);
        wrap_nxt = (wrap_ev && (wrap_count != WRAP_MAX)) ? wrap_count + 1'b1 : wrap_count;

        // An ack restarts the pending count, keeping a wrap that lands on the same edge.
        pend_nxt = pend_cnt;
        if (irq_ack && irq)
            pend_nxt = wrap_ev ? WRAP_W'(1) : '0;
        else if (wrap_ev && (pend_cnt < THRESH))
            pend_nxt = pend_cnt + 1'b1;

        // New detections win over a concurrent clear.
        err_nxt = (err_clr ? 2'b00 : err) | {ill_step, wrap_ev & ~ovf_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_prev   <= '0;
            ovf_prev   <= 1'b0;
            primed     <= 1'b0;
            pend_cnt   <= '0;
            wrap_count <= '0;
            wrap_sat   <= 1'b0;
            irq        <= 1'b0;
            err        <= 2'b00;
            snap_valid <= 1'b0;
            snap_cnt   <= '0;
            snap_wraps <= '0;
        end else begin
            cnt_prev   <= cnt_in;
            ovf_prev   <= ovf_in;
            primed     <= 1'b1;
            pend_cnt   <= pend_nxt;
            wrap_count <= wrap_nxt;
            wrap_sat   <= wrap_sat | (wrap_nxt == WRAP_MAX);
            irq        <= (pend_nxt >= THRESH);
            err        <= err_nxt;
            snap_valid <= snap_req;
            if (snap_req) begin
                snap_cnt   <= cnt_in;
                snap_wraps <= wrap_nxt;
            end
        end
    end
endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor: vector table plus multi-cycle sequences,
// with a second instance at IRQ_THRESH=1 for the ack/wrap coincidence.
module tb_counter_wrap_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_in = '0;
    logic       ovf_in = 1'b0;
    logic       irq_ack = 1'b0;
    logic       snap_req = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] wrap_count, snap_wraps;
    logic       wrap_sat, irq, snap_valid;
    logic [1:0] err;
    logic [3:0] snap_cnt;

    logic [7:0] wrap_count1, snap_wraps1;
    logic       wrap_sat1, irq1, snap_valid1;
    logic [1:0] err1;
    logic [3:0] snap_cnt1;

    counter_wrap_monitor #(.CNT_W(4), .WRAP_W(8), .IRQ_THRESH(4)) dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .ovf_in(ovf_in), .irq_ack(irq_ack),
        .snap_req(snap_req), .err_clr(err_clr), .wrap_count(wrap_count), .wrap_sat(wrap_sat),
        .irq(irq), .err(err), .snap_valid(snap_valid), .snap_cnt(snap_cnt), .snap_wraps(snap_wraps)
    );

    counter_wrap_monitor #(.CNT_W(4), .WRAP_W(8), .IRQ_THRESH(1)) dut1 (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .ovf_in(ovf_in), .irq_ack(irq_ack),
        .snap_req(snap_req), .err_clr(err_clr), .wrap_count(wrap_count1), .wrap_sat(wrap_sat1),
        .irq(irq1), .err(err1), .snap_valid(snap_valid1), .snap_cnt(snap_cnt1), .snap_wraps(snap_wraps1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit auto_ack = 0;
    int ack_cd = 0;
    int n_irq = 0;
    bit irq_seen = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       ovf, snap, clr;
        int         wc, er, irqv, sv, sc, sw;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs for one edge, then sample 1 time unit after it.
    task automatic drive(input logic [3:0] c, input logic o);
        cnt_in = c;
        ovf_in = o;
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (irq && !irq_seen) begin
                n_irq++;
                ack_cd = 2;
            end
            irq_seen = irq;
            if (ack_cd > 0) begin
                ack_cd--;
                irq_ack = (ack_cd == 0);
            end else begin
                irq_ack = 1'b0;
            end
        end
    endtask

    task automatic wrap_once(input logic o);
        for (int c = 1; c < 16; c++) drive(4'(c), 1'b0);
        drive(4'd0, o);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        irq_ack = 0; snap_req = 0; err_clr = 0;
        drive(4'd0, 1'b0);
        chk("rst_wrap_count", wrap_count, 0);
        chk("rst_wrap_sat", wrap_sat, 0);
        chk("rst_irq", irq, 0);
        chk("rst_err", err, 0);
        chk("rst_snap", {snap_valid, snap_cnt, snap_wraps}, 0);
        chk("rst_irq_t1", irq1, 0);
        reset = 1'b0;
    endtask

    initial begin
        vt[0]  = '{4'd14, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{4'd14, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[4]  = '{4'd0,  1, 0, 0, 1, 0, 0, 0, 0, 0};
        vt[5]  = '{4'd0,  0, 1, 0, 1, 0, 0, 1, 0, 1};
        vt[6]  = '{4'd1,  0, 0, 0, 1, 0, 0, 0, 0, 1};
        vt[7]  = '{4'd2,  0, 1, 0, 1, 0, 0, 1, 2, 1};
        vt[8]  = '{4'd1,  0, 0, 0, 1, 2, 0, 0, 2, 1};
        vt[9]  = '{4'd1,  0, 0, 1, 1, 0, 0, 0, 2, 1};
        vt[10] = '{4'd3,  0, 0, 0, 1, 2, 0, 0, 2, 1};

        // Basic patterns: primed suppression, hold, increment, wrap, snapshot, errors
        do_reset();
        for (int i = 0; i < 11; i++) begin
            snap_req = vt[i].snap;
            err_clr  = vt[i].clr;
            drive(vt[i].cnt, vt[i].ovf);
            chk($sformatf("vec%0d_wrap_count", i), wrap_count, vt[i].wc);
            chk($sformatf("vec%0d_err", i), err, vt[i].er);
            chk($sformatf("vec%0d_irq", i), irq, vt[i].irqv);
            chk($sformatf("vec%0d_snap_valid", i), snap_valid, vt[i].sv);
            chk($sformatf("vec%0d_snap_cnt", i), snap_cnt, vt[i].sc);
            chk($sformatf("vec%0d_snap_wraps", i), snap_wraps, vt[i].sw);
        end
        snap_req = 0; err_clr = 0;

        // Clean run: 40 wraps, auto-ack two cycles after each interrupt
        do_reset();
        auto_ack = 1; n_irq = 0; irq_seen = 0; ack_cd = 0;
        for (int w = 0; w < 40; w++) wrap_once(1'b1);
        for (int i = 0; i < 4; i++) drive(4'd0, 1'b0);
        auto_ack = 0; irq_ack = 0;
        chk("clean_wrap_count", wrap_count, 40);
        chk("clean_irq_count", n_irq, 10);
        chk("clean_irq_low", irq, 0);
        chk("clean_err", err, 0);
        chk("clean_wrap_sat", wrap_sat, 0);

        // Saturation at 255
        do_reset();
        for (int w = 0; w < 254; w++) wrap_once(1'b1);
        chk("sat_254_count", wrap_count, 254);
        chk("sat_254_flag", wrap_sat, 0);
        wrap_once(1'b1);
        chk("sat_255_count", wrap_count, 255);
        chk("sat_255_flag", wrap_sat, 1);
        for (int w = 0; w < 45; w++) wrap_once(1'b1);
        chk("sat_300_count", wrap_count, 255);
        chk("sat_300_flag", wrap_sat, 1);
        snap_req = 1;
        drive(4'd0, 1'b0);
        snap_req = 0;
        chk("sat_snap_valid", snap_valid, 1);
        chk("sat_snap_wraps", snap_wraps, 255);

        // Unflagged wrap
        do_reset();
        wrap_once(1'b0);
        chk("unfl_err", err, 1);
        chk("unfl_wrap_count", wrap_count, 1);
        for (int i = 0; i < 3; i++) drive(4'd0, 1'b0);
        chk("unfl_sticky", err, 1);
        err_clr = 1;
        drive(4'd0, 1'b0);
        err_clr = 0;
        chk("unfl_cleared", err, 0);

        // Illegal steps 3->7 then 9->0 with concurrent clear
        do_reset();
        drive(4'd0, 0); drive(4'd1, 0); drive(4'd2, 0); drive(4'd3, 0);
        chk("ill_pre", err, 0);
        drive(4'd7, 0);
        chk("ill_jump", err, 2);
        drive(4'd8, 0); drive(4'd9, 0);
        err_clr = 1;
        drive(4'd0, 0);
        chk("ill_set_wins", err, 2);
        chk("ill_no_wrap", wrap_count, 0);
        drive(4'd0, 0);
        err_clr = 0;
        chk("ill_clear", err, 0);

        // Snapshot coinciding with the 6th wrap, then back-to-back
        do_reset();
        for (int w = 0; w < 5; w++) wrap_once(1'b1);
        for (int c = 1; c < 16; c++) drive(4'(c), 1'b0);
        snap_req = 1;
        drive(4'd0, 1'b1);
        chk("snapw_valid", snap_valid, 1);
        chk("snapw_cnt", snap_cnt, 0);
        chk("snapw_wraps", snap_wraps, 6);
        drive(4'd1, 1'b0);
        snap_req = 0;
        chk("snap_b2b_valid", snap_valid, 1);
        chk("snap_b2b_cnt", snap_cnt, 1);
        drive(4'd2, 1'b0);
        chk("snap_end_valid", snap_valid, 0);
        chk("snap_hold_cnt", snap_cnt, 1);
        chk("snap_hold_wraps", snap_wraps, 6);

        // Reset mid-run with irq=1 and err=3
        do_reset();
        for (int w = 0; w < 4; w++) wrap_once(1'b0);
        drive(4'd5, 1'b0);
        chk("mid_pre_irq", irq, 1);
        chk("mid_pre_err", err, 3);
        do_reset();
        drive(4'd9, 1'b0);
        chk("mid_first_sample_err", err, 0);
        drive(4'd10, 1'b0);
        chk("mid_second_err", err, 0);
        chk("mid_wrap_count", wrap_count, 0);

        // IRQ_THRESH=1: ack on the same edge as a wrap keeps irq high
        do_reset();
        wrap_once(1'b1);
        chk("t1_irq_first", irq1, 1);
        chk("t4_irq_first", irq, 0);
        for (int c = 1; c < 16; c++) drive(4'(c), 1'b0);
        irq_ack = 1;
        drive(4'd0, 1'b1);
        chk("t1_ack_with_wrap", irq1, 1);
        chk("t1_wrap_count", wrap_count1, 2);
        drive(4'd1, 1'b0);
        irq_ack = 0;
        chk("t1_ack_drop", irq1, 0);
        wrap_once(1'b1);
        wrap_once(1'b1);
        chk("t4_ignored_ack_irq", irq, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_wrap_monitor.md
# counter_wrap_monitor

Checker and event-capture stage that sits directly downstream of the 4-bit up-counter (`first_counter`). It consumes the counter's `counter_out`/`overflow_out` pair and performs three jobs:
- counts wrap-around events into a saturating wrap counter;
- raises a handshaked interrupt every `IRQ_THRESH` wraps;
- flags protocol errors: a wrap that the overflow flag did not report, or an illegal count step.

It also provides an on-demand snapshot of count and wraps for software readout.

## Interface
Parameters:
- `CNT_W`, 4, width of the monitored count.
- `WRAP_W`, 8, width of the wrap counter.
- `IRQ_THRESH`, 4, wraps per interrupt. Legal range is 1..2^WRAP_W-1.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cnt_in`  in  CNT_W  upstream `counter_out`.
- `ovf_in`  in  1  upstream `overflow_out` (level).
- `irq_ack`  in  1  interrupt acknowledge.
- `snap_req`  in  1  snapshot request, one-cycle pulse.
- `err_clr`  in  1  clears sticky error bits.
- `wrap_count`  out  WRAP_W  saturating count of wraps.
- `wrap_sat`  out  1  sticky; `wrap_count` has reached all-ones.
- `irq`  out  1  interrupt, level, held until acknowledged.
- `err`  out  2  sticky errors:
  - bit0: unflagged wrap.
  - bit1: illegal step.
- `snap_valid`  out  1  one-cycle strobe.
- `snap_cnt`  out  CNT_W  captured count.
- `snap_wraps`  out  WRAP_W  captured wrap count.

## Operation
- **Reset.** On reset=1, all outputs and internal state clear to 0: `wrap_count`, `wrap_sat`, `irq`, `err`, `snap_valid`, `snap_cnt`, `snap_wraps`, `cnt_prev`, `ovf_prev`, `pend_cnt`, `primed`. Reset overrides every other input in that cycle.
- **Internal state.**
  - `cnt_prev` and `ovf_prev` hold the previous cycle's inputs.
  - `primed` is set one cycle after reset release. Comparisons against `cnt_prev` are suppressed while `primed`=0, so the first sample after reset never produces W or an error.
- **Wrap event W.** W = `primed` & (`cnt_prev` == 2^CNT_W-1) & (`cnt_in` == 0).
- **Wrap counter.**
  - On W, `wrap_count` increments.
  - At all-ones it holds. `wrap_sat` sets on the edge where `wrap_count` becomes all-ones and stays set until reset.
- **Error bit0 (unflagged wrap).** Sets on W when `ovf_in`=0 in the same cycle. The upstream stage asserts `overflow_out` on the same edge its count goes 15->0.
- **Error bit1 (illegal step).** Sets when `primed` and `cnt_in` is neither `cnt_prev` nor `cnt_prev`+1 mod 2^CNT_W. Holding and incrementing are legal; a return to 0 from a non-max value is illegal.
- **Error clear.** `err` bits are sticky. `err_clr`=1 clears them at the next edge. If a new error is detected in the same cycle as `err_clr`, set wins.
- **Interrupt.**
  - `pend_cnt` (internal, saturates at `IRQ_THRESH`) counts W since the last acknowledge.
  - `irq` <= (`pend_cnt`' >= `IRQ_THRESH`), where `pend_cnt`' is the post-update value.
  - `irq_ack`=1 while `irq`=1: `pend_cnt` <= (W ? 1 : 0) and `irq` <= 0, unless `IRQ_THRESH`=1 and W, in which case `irq` stays 1.
  - `irq_ack` while `irq`=0 is ignored.
- **Snapshot.**
  - `snap_req`=1 at edge k: `snap_cnt` <= `cnt_in` and `snap_wraps` <= `wrap_count`', where `wrap_count`' includes a W detected at edge k.
  - `snap_valid` is 1 for the cycle following edge k only.
  - Back-to-back requests produce back-to-back strobes, each carrying fresh data.
  - `snap_cnt`/`snap_wraps` hold their value between requests.
- `ovf_in` is used only for the bit0 check. `ovf_prev` is kept for debug and the rising-edge trace.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- W at edge k: `wrap_count`, `wrap_sat`, `irq` and `err` are updated immediately after edge k, i.e. one cycle after `cnt_in`=0 is presented.
- Interrupt latency: the `IRQ_THRESH`-th wrap raises `irq` at the same edge that increments `wrap_count`.
- Acknowledge: `irq` drops the edge after `irq_ack` is sampled high.
- Snapshot latency is 1 cycle.
- Reset mid-operation: all state clears at that edge, and `primed` re-arms one cycle after release.
- The upstream counter running slower (enable low) is legal; held values produce no events.

## Test plan
- **Clean run.** Reset, then drive `cnt_in` 0..15 repeatedly with `ovf_in`=1 on each 15->0 cycle, 40 wraps, `IRQ_THRESH`=4, ack 2 cycles after each irq. Required: `wrap_count`=40, 10 irq assertions, `err`=0, `wrap_sat`=0.
- **Saturation.** Run 300 wraps. Required: `wrap_count` holds at 255 and `wrap_sat`=1 from the 255th wrap. A snapshot requested after that returns `snap_wraps`=255.
- **Unflagged wrap.** 15->0 with `ovf_in`=0 (the buggy upstream behaviour). Required: `err`[0]=1 the cycle after, `wrap_count` still increments, and `err` stays set until `err_clr`.
- **Illegal step.** `cnt_in` 3->7, then 9->0. Required: `err`[1]=1 after the first jump. Apply `err_clr` concurrently with the second jump: `err`[1] remains 1.
- **Snapshot with simultaneous wrap.** `wrap_count`=5, `snap_req` on the 15->0 edge. Required: `snap_valid`=1 next cycle with `snap_cnt`=0 and `snap_wraps`=6. Back-to-back `snap_req` gives two consecutive strobes.
- **Reset mid-run and ack corner.** Assert reset with `irq`=1 and `err`=3. Required: all outputs 0 next cycle, and a first sample of `cnt_in`=0 after release with `cnt_prev`=0 flags nothing. Separately, with `IRQ_THRESH`=1, ack coinciding with W keeps `irq`=1.
